// File: rtl/mem_stage.sv
// Memory stage: 3072-word little-endian data memory with combinational
// reads, byte-lane writes on the clock edge, address/alignment exception
// detection and write-back value selection. The stage has zero latency.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_PC_M,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  wb_sel,
    input  logic [4:0]  a_WB_in,
    output logic [31:0] v_WB_M,
    output logic [4:0]  a_WB_M,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int DEPTH = 3072;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_e;

    // Memory contents start at zero at power-up as well as after reset.
    logic [31:0] mem_q [0:DEPTH-1] = '{default: 32'd0};

    logic        is_load;
    logic        is_store;
    logic        size_word;
    logic        size_half;
    logic        size_byte;
    logic        load_signed;
    logic        misaligned;
    logic        in_range;
    logic        addr_err;
    logic [11:0] word_idx;
    logic [31:0] rd_word;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;
    logic [31:0] load_data;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_en;

    // Decode the operation into class (load/store), access size and signedness.
    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        size_word   = 1'b0;
        size_half   = 1'b0;
        size_byte   = 1'b0;
        load_signed = 1'b0;
        case (mem_op)
            OP_LW:   begin is_load  = 1'b1; size_word = 1'b1; end
            OP_LH:   begin is_load  = 1'b1; size_half = 1'b1; load_signed = 1'b1; end
            OP_LHU:  begin is_load  = 1'b1; size_half = 1'b1; end
            OP_LB:   begin is_load  = 1'b1; size_byte = 1'b1; load_signed = 1'b1; end
            OP_LBU:  begin is_load  = 1'b1; size_byte = 1'b1; end
            OP_SW:   begin is_store = 1'b1; size_word = 1'b1; end
            OP_SH:   begin is_store = 1'b1; size_half = 1'b1; end
            OP_SB:   begin is_store = 1'b1; size_byte = 1'b1; end
            default: ;
        endcase
    end

    assign word_idx   = addr[13:2];
    assign in_range   = (addr < 32'h0000_3000);
    assign misaligned = (size_word && (addr[1:0] != 2'b00)) || (size_half && addr[0]);
    assign addr_err   = misaligned || !in_range;
    assign exc_adel   = is_load && addr_err;
    assign exc_ades   = is_store && addr_err;

    // Out-of-range addresses never index the array; the word reads as zero.
    assign rd_word = in_range ? mem_q[word_idx] : 32'd0;

    // Extract the addressed halfword/byte and extend to 32 bits.
    always_comb begin
        rd_half   = addr[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte   = rd_word[8*addr[1:0] +: 8];
        load_data = 32'd0;
        if (is_load && !addr_err) begin
            if (size_word)
                load_data = rd_word;
            else if (size_half)
                load_data = {{16{load_signed & rd_half[15]}}, rd_half};
            else
                load_data = {{24{load_signed & rd_byte[7]}}, rd_byte};
        end
    end

    // Build byte-lane enables and lane-replicated store data.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = wdata;
        if (size_word) begin
            wr_be = 4'b1111;
        end else if (size_half) begin
            wr_be   = addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata[15:0]}};
        end else if (size_byte) begin
            wr_be   = 4'b0001 << addr[1:0];
            wr_data = {4{wdata[7:0]}};
        end
    end

    // A faulting store or one coincident with reset never touches memory.
    assign wr_en = is_store && !addr_err && !reset;

    // Memory update: clear everything on reset, otherwise commit enabled lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 32'd0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b])
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Write-back source selection; the link value wraps modulo 2^32.
    always_comb begin
        v_WB_M = 32'd0;
        case (wb_sel)
            2'd0:    v_WB_M = addr;
            2'd1:    v_WB_M = load_data;
            2'd2:    v_WB_M = a_PC_M + 32'd8;
            default: v_WB_M = 32'd0;
        endcase
    end

    assign a_WB_M = exc_adel ? 5'd0 : a_WB_in;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors with literal expected
// values, then a random aligned store/load phase checked against a small
// reference memory. Expectations go through a scoreboard queue.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [31:0] a_PC_M;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wb_sel;
    logic [4:0]  a_WB_in;
    logic [31:0] v_WB_M;
    logic [4:0]  a_WB_M;
    logic        exc_adel;
    logic        exc_ades;

    mem_stage dut (
        .clk      (clk),
        .reset    (reset),
        .a_PC_M   (a_PC_M),
        .mem_op   (mem_op),
        .addr     (addr),
        .wdata    (wdata),
        .wb_sel   (wb_sel),
        .a_WB_in  (a_WB_in),
        .v_WB_M   (v_WB_M),
        .a_WB_M   (a_WB_M),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] v;
        logic [4:0]  a;
        logic        adel;
        logic        ades;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [0:15];

    localparam logic [3:0] LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4, LBU = 4'd5;
    localparam logic [3:0] SW = 4'd6, SH = 4'd7, SB = 4'd8;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive one transaction at the falling edge, queue its expectation, then
    // compare once the combinational outputs have settled.
    task automatic drive_op(input string tag, input logic rst, input logic [3:0] op,
                            input logic [31:0] ad, input logic [31:0] wd, input logic [1:0] ws,
                            input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] ev, input logic eadel, input logic eades);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset   = rst;
        mem_op  = op;
        addr    = ad;
        wdata   = wd;
        wb_sel  = ws;
        a_PC_M  = pc;
        a_WB_in = rd;
        e.v    = ev;
        e.a    = eadel ? 5'd0 : rd;
        e.adel = eadel;
        e.ades = eades;
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        $display("%s: rst=%0d op=%0d addr=%08h wdata=%08h wb_sel=%0d -> v=%08h a=%0d adel=%0b ades=%0b",
                 tag, rst, op, ad, wd, ws, v_WB_M, a_WB_M, exc_adel, exc_ades);
        check_val({tag, ".v"},    v_WB_M,            g.v);
        check_val({tag, ".a"},    {27'd0, a_WB_M},   {27'd0, g.a});
        check_val({tag, ".adel"}, {31'd0, exc_adel}, {31'd0, g.adel});
        check_val({tag, ".ades"}, {31'd0, exc_ades}, {31'd0, g.ades});
    endtask

    function automatic logic [31:0] mdl_load(input logic [3:0] op, input logic [31:0] ad);
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b;
        w = ref_mem[ad[5:2]];
        h = ad[1] ? w[31:16] : w[15:0];
        b = w[8*ad[1:0] +: 8];
        case (op)
            LW:      return w;
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'd0, h};
            LB:      return {{24{b[7]}}, b};
            default: return {24'd0, b};
        endcase
    endfunction

    task automatic mdl_store(input logic [3:0] op, input logic [31:0] ad, input logic [31:0] wd);
        if (op == SW)
            ref_mem[ad[5:2]] = wd;
        else if (op == SH)
            ref_mem[ad[5:2]][16*ad[1] +: 16] = wd[15:0];
        else
            ref_mem[ad[5:2]][8*ad[1:0] +: 8] = wd[7:0];
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [4:0]  rd;

        reset = 1'b1; mem_op = 4'd0; addr = 32'd0; wdata = 32'd0;
        wb_sel = 2'd0; a_PC_M = 32'd0; a_WB_in = 5'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;

        drive_op("reset",    1, 4'd0, 32'h0,  32'h0, 2'd0, 32'h0, 5'd3, 32'h0, 0, 0);

        drive_op("sw10",     0, SW,  32'h10, 32'h12345678, 2'd0, 32'h0, 5'd7, 32'h10, 0, 0);
        drive_op("lw10",     0, LW,  32'h10, 32'h0, 2'd1, 32'h0, 5'd7, 32'h12345678, 0, 0);
        drive_op("sb13",     0, SB,  32'h13, 32'hAB, 2'd0, 32'h0, 5'd7, 32'h13, 0, 0);
        drive_op("lb13",     0, LB,  32'h13, 32'h0, 2'd1, 32'h0, 5'd8, 32'hFFFFFFAB, 0, 0);
        drive_op("lbu13",    0, LBU, 32'h13, 32'h0, 2'd1, 32'h0, 5'd8, 32'h000000AB, 0, 0);
        drive_op("lw10b",    0, LW,  32'h10, 32'h0, 2'd1, 32'h0, 5'd8, 32'hAB345678, 0, 0);
        drive_op("sh22",     0, SH,  32'h22, 32'h8001, 2'd0, 32'h0, 5'd9, 32'h22, 0, 0);
        drive_op("lh22",     0, LH,  32'h22, 32'h0, 2'd1, 32'h0, 5'd9, 32'hFFFF8001, 0, 0);
        drive_op("lhu22",    0, LHU, 32'h22, 32'h0, 2'd1, 32'h0, 5'd9, 32'h00008001, 0, 0);
        drive_op("lw20",     0, LW,  32'h20, 32'h0, 2'd1, 32'h0, 5'd9, 32'h80010000, 0, 0);

        drive_op("sw0",      0, SW,  32'h0,    32'h55AA0001, 2'd0, 32'h0, 5'd4, 32'h0, 0, 0);
        drive_op("lw2",      0, LW,  32'h2,    32'h0, 2'd1, 32'h0, 5'd4, 32'h0, 1, 0);
        drive_op("sw3000",   0, SW,  32'h3000, 32'hFFFFFFFF, 2'd0, 32'h0, 5'd4, 32'h3000, 0, 1);
        drive_op("lw3000",   0, LW,  32'h3000, 32'h0, 2'd1, 32'h0, 5'd4, 32'h0, 1, 0);
        drive_op("sw1",      0, SW,  32'h1,    32'hFFFFFFFF, 2'd0, 32'h0, 5'd4, 32'h1, 0, 1);
        drive_op("sh3",      0, SH,  32'h3,    32'hFFFFFFFF, 2'd0, 32'h0, 5'd4, 32'h3, 0, 1);
        drive_op("lh1",      0, LH,  32'h1,    32'h0, 2'd1, 32'h0, 5'd4, 32'h0, 1, 0);
        drive_op("lw0",      0, LW,  32'h0,    32'h0, 2'd1, 32'h0, 5'd4, 32'h55AA0001, 0, 0);
        drive_op("sw2ffc",   0, SW,  32'h2FFC, 32'h11223344, 2'd0, 32'h0, 5'd5, 32'h2FFC, 0, 0);
        drive_op("lb2fff",   0, LB,  32'h2FFF, 32'h0, 2'd1, 32'h0, 5'd5, 32'h00000011, 0, 0);
        drive_op("lh3000",   0, LHU, 32'h3000, 32'h0, 2'd1, 32'h0, 5'd5, 32'h0, 1, 0);

        drive_op("sw40",     0, SW,  32'h40, 32'hDEADBEEF, 2'd0, 32'h0, 5'd6, 32'h40, 0, 0);
        drive_op("rst_sw44", 1, SW,  32'h44, 32'hCAFEF00D, 2'd0, 32'h0, 5'd6, 32'h44, 0, 0);
        drive_op("lw40",     0, LW,  32'h40, 32'h0, 2'd1, 32'h0, 5'd6, 32'h0, 0, 0);
        drive_op("lw44",     0, LW,  32'h44, 32'h0, 2'd1, 32'h0, 5'd6, 32'h0, 0, 0);
        drive_op("lw10rst",  0, LW,  32'h10, 32'h0, 2'd1, 32'h0, 5'd6, 32'h0, 0, 0);

        drive_op("pc8wrap",  0, 4'd0, 32'h0,    32'h0, 2'd2, 32'hFFFFFFFC, 5'd31, 32'h4, 0, 0);
        drive_op("pc8",      0, 4'd0, 32'h0,    32'h0, 2'd2, 32'h00400100, 5'd31, 32'h00400108, 0, 0);
        drive_op("alu3004",  0, 4'd0, 32'h3004, 32'h0, 2'd0, 32'h0, 5'd2, 32'h3004, 0, 0);
        drive_op("zero_sel", 0, LW,   32'h10,   32'h0, 2'd3, 32'h0, 5'd2, 32'h0, 0, 0);
        drive_op("op9",      0, 4'd9, 32'h3003, 32'h0, 2'd1, 32'h0, 5'd2, 32'h0, 0, 0);

        // Random aligned traffic in words 0x100-0x13C, which are zero after the reset above.
        for (int i = 0; i < 48; i++) begin
            rd = 5'($urandom_range(1, 31));
            ad = 32'h100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                op = 4'($urandom_range(6, 8));
                wd = $urandom;
                if (op == SH) ad[1] = 1'($urandom_range(0, 1));
                if (op == SB) ad[1:0] = 2'($urandom_range(0, 3));
                drive_op("rnd_st", 0, op, ad, wd, 2'd0, 32'h0, rd, ad, 0, 0);
                mdl_store(op, ad, wd);
            end else begin
                op = 4'($urandom_range(1, 5));
                if (op == LH || op == LHU) ad[1] = 1'($urandom_range(0, 1));
                if (op == LB || op == LBU) ad[1:0] = 2'($urandom_range(0, 3));
                drive_op("rnd_ld", 0, op, ad, 32'h0, 2'd1, 32'h0, rd, mdl_load(op, ad), 0, 0);
            end
        end

        @(negedge clk);
        mem_op = 4'd0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
